// File: rtl/serial_sub.sv
// Multi-cycle N-bit subtractor: a - b - bin, STEP bits per clock, with borrow-out.
// start/busy/done handshake; dif/bo stay registered until the next completion.
module serial_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dif,
  output logic             bo
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_step
    $error("serial_sub: STEP must divide WIDTH and satisfy 1 <= STEP <= WIDTH");
  end

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, dif_q;
  logic             borrow_q, bo_q, done_q;
  logic [CW-1:0]    cnt_q;

  logic [STEP:0]    chunk_d;
  logic [WIDTH-1:0] res_d;
  logic             last_d;

  // The extra MSB of the (STEP+1)-bit difference is the chunk's borrow-out.
  always_comb begin
    chunk_d = {1'b0, a_q[STEP-1:0]} - {1'b0, b_q[STEP-1:0]} - {{STEP{1'b0}}, borrow_q};
    res_d   = (res_q >> STEP) | (WIDTH'(chunk_d[STEP-1:0]) << (WIDTH - STEP));
    last_d  = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      dif_q    <= '0;
      borrow_q <= 1'b0;
      bo_q     <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            res_q    <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_q      <= a_q >> STEP;
          b_q      <= b_q >> STEP;
          borrow_q <= chunk_d[STEP];
          res_q    <= res_d;
          if (last_d) begin
            dif_q   <= res_d;
            bo_q    <= chunk_d[STEP];
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign dif  = dif_q;
  assign bo   = bo_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: four configurations checked every cycle against an
// arithmetic model, plus directed vectors with hand-computed results.
module tb_serial_sub;

  localparam int NI = 4;
  localparam int WS [NI] = '{8, 8, 1, 16};
  localparam int SS [NI] = '{1, 4, 1, 4};
  localparam int NS [NI] = '{8, 2, 1, 4};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s [NI];
  logic [15:0] a_s     [NI];
  logic [15:0] b_s     [NI];
  logic        bin_s   [NI];
  logic        busy_s  [NI];
  logic        done_s  [NI];
  logic [15:0] dif_s   [NI];
  logic        bo_s    [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned W = WS[g];
    localparam int unsigned S = SS[g];
    logic [W-1:0] dif_l;
    logic         bo_l, busy_l, done_l;
    serial_sub #(.WIDTH(W), .STEP(S)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_s[g]),
      .a     (a_s[g][W-1:0]),
      .b     (b_s[g][W-1:0]),
      .bin   (bin_s[g]),
      .busy  (busy_l),
      .done  (done_l),
      .dif   (dif_l),
      .bo    (bo_l)
    );
    assign dif_s[g]  = 16'(dif_l);
    assign bo_s[g]   = bo_l;
    assign busy_s[g] = busy_l;
    assign done_s[g] = done_l;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] msk(input int w);
    return (32'h1 << w) - 32'h1;
  endfunction

  function automatic logic [31:0] mdif(input int i, input logic [15:0] av, input logic [15:0] bv, input logic bi);
    return ((32'(av) & msk(WS[i])) - (32'(bv) & msk(WS[i])) - 32'(bi)) & msk(WS[i]);
  endfunction

  function automatic logic mbo(input int i, input logic [15:0] av, input logic [15:0] bv, input logic bi);
    return (32'(av) & msk(WS[i])) < ((32'(bv) & msk(WS[i])) + 32'(bi));
  endfunction

  // Model: each instance counts down N cycles after an accepted start.
  int          m_left [NI];
  logic [31:0] m_pd   [NI];
  logic        m_pb   [NI];
  logic [31:0] m_dif  [NI];
  logic        m_bo   [NI];
  logic        m_done [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_left[i] <= 0;
        m_pd[i]   <= '0;
        m_pb[i]   <= 1'b0;
        m_dif[i]  <= '0;
        m_bo[i]   <= 1'b0;
        m_done[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (m_left[i] == 0) begin
          m_done[i] <= 1'b0;
          if (start_s[i]) begin
            m_left[i] <= NS[i];
            m_pd[i]   <= mdif(i, a_s[i], b_s[i], bin_s[i]);
            m_pb[i]   <= mbo(i, a_s[i], b_s[i], bin_s[i]);
          end
        end else if (m_left[i] == 1) begin
          m_left[i] <= 0;
          m_dif[i]  <= m_pd[i];
          m_bo[i]   <= m_pb[i];
          m_done[i] <= 1'b1;
        end else begin
          m_left[i] <= m_left[i] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("busy[%0d]", i), 32'(busy_s[i]), 32'(m_left[i] != 0));
      chk($sformatf("done[%0d]", i), 32'(done_s[i]), 32'(m_done[i]));
      chk($sformatf("dif[%0d]", i),  32'(dif_s[i]),  m_dif[i]);
      chk($sformatf("bo[%0d]", i),   32'(bo_s[i]),   32'(m_bo[i]));
    end
  end

  task automatic wait_done(input int i, output int lat);
    bit got = 1'b0;
    lat = 0;
    repeat (40) begin
      if (!got) begin
        @(posedge clk); #1;
        lat++;
        if (done_s[i]) got = 1'b1;
      end
    end
  endtask

  task automatic op(input int i, input logic [15:0] av, input logic [15:0] bv, input logic bi,
                    input logic [15:0] ed, input logic eb, input int elat);
    int lat;
    @(negedge clk);
    a_s[i] = av; b_s[i] = bv; bin_s[i] = bi; start_s[i] = 1'b1;
    @(posedge clk); #1;
    start_s[i] = 1'b0;
    a_s[i] = ~av; b_s[i] = ~bv; bin_s[i] = ~bi;
    chk("busy_after_accept", 32'(busy_s[i]), 32'd1);
    wait_done(i, lat);
    chk("latency", 32'(lat), 32'(elat));
    chk("dif_lit", 32'(dif_s[i]), 32'(ed));
    chk("bo_lit",  32'(bo_s[i]),  32'(eb));
  endtask

  initial begin
    int lat;
    logic [15:0] ra, rb;
    logic        rbi;
    logic [16:0] full;

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0; a_s[i] = '0; b_s[i] = '0; bin_s[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset, no spurious done
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy_s[0]), 32'd0);
    chk("idle_done", 32'(done_s[0]), 32'd0);
    chk("idle_dif",  32'(dif_s[0]),  32'd0);
    chk("idle_bo",   32'(bo_s[0]),   32'd0);

    // WIDTH=8 STEP=1
    op(0, 16'h05, 16'h03, 1'b0, 16'h02, 1'b0, 8);
    op(0, 16'h03, 16'h05, 1'b0, 16'hFE, 1'b1, 8);
    op(0, 16'h00, 16'h00, 1'b1, 16'hFF, 1'b1, 8);
    op(0, 16'hFF, 16'hFF, 1'b0, 16'h00, 1'b0, 8);

    // WIDTH=8 STEP=4
    op(1, 16'hA0, 16'h0F, 1'b0, 16'h91, 1'b0, 2);
    op(1, 16'h10, 16'h01, 1'b1, 16'h0E, 1'b0, 2);
    op(1, 16'h00, 16'hFF, 1'b1, 16'h00, 1'b1, 2);

    // Handshake: start while busy is ignored; start in done cycle is accepted
    @(negedge clk);
    a_s[0] = 16'h10; b_s[0] = 16'h01; bin_s[0] = 1'b0; start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_s[0] = 16'hFF; b_s[0] = 16'h00; start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    wait_done(0, lat);
    chk("hs_latency", 32'(lat), 32'd5);
    chk("hs_dif", 32'(dif_s[0]), 32'h0F);
    chk("hs_bo",  32'(bo_s[0]),  32'd0);
    a_s[0] = 16'h20; b_s[0] = 16'h21; bin_s[0] = 1'b0; start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    chk("hs_done_single", 32'(done_s[0]), 32'd0);
    chk("hs_b2b_busy",    32'(busy_s[0]), 32'd1);
    wait_done(0, lat);
    chk("hs_b2b_latency", 32'(lat), 32'd8);
    chk("hs_b2b_dif", 32'(dif_s[0]), 32'hFF);
    chk("hs_b2b_bo",  32'(bo_s[0]),  32'd1);

    // Reset mid-operation
    @(negedge clk);
    a_s[0] = 16'h05; b_s[0] = 16'h03; bin_s[0] = 1'b0; start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_s[0]), 32'd0);
    chk("rst_done", 32'(done_s[0]), 32'd0);
    chk("rst_dif",  32'(dif_s[0]),  32'd0);
    chk("rst_bo",   32'(bo_s[0]),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("rst_no_done", 32'(dif_s[0]), 32'd0);
    op(0, 16'h05, 16'h03, 1'b0, 16'h02, 1'b0, 8);

    // Half-subtractor truth table
    op(2, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1);
    op(2, 16'h0, 16'h1, 1'b0, 16'h1, 1'b1, 1);
    op(2, 16'h1, 16'h0, 1'b0, 16'h1, 1'b0, 1);
    op(2, 16'h1, 16'h1, 1'b0, 16'h0, 1'b0, 1);

    // WIDTH=16 STEP=4 randomized
    for (int k = 0; k < 1000; k++) begin
      ra   = 16'($urandom_range(0, 65535));
      rb   = 16'($urandom_range(0, 65535));
      rbi  = 1'($urandom_range(0, 1));
      full = {1'b0, ra} - {1'b0, rb} - {16'b0, rbi};
      op(3, ra, rb, rbi, full[15:0], full[16], 4);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
